// File: rtl/or_reduce_sched_pkg.sv
// or_reduce_sched_pkg: scheduler state encodings and requester count shared by the reduction schedulers
package or_reduce_sched_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/or_reduce_sched_if.sv
// or_reduce_sched_if: request/response handshake bundle of the OR-reduction scheduler
interface or_reduce_sched_if
  import or_reduce_sched_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic                     resp_id;
  logic                     resp_out;
  logic                     busy;
  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_out, busy
  );
  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_out, busy
  );
endinterface

// File: rtl/or_reduce_sched_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on contention the requester that did not win last time wins
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);
  assign gnt[0] = en & req[0] & (~req[1] | last_grant);
  assign gnt[1] = en & req[1] & (~req[0] | ~last_grant);
endmodule

// File: rtl/or_reduce_sched.sv
// or_reduce_sched: time-shared bit-serial OR-reduction engine serving two requesters
module or_reduce_sched
  import or_reduce_sched_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  or_reduce_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic               out_q, out_d;
  logic [NUM_REQ-1:0] gnt;
  logic               fin;
  rr_arbiter2 u_arb (
    .req       (bus.req_valid),
    .last_grant(last_q),
    .en        (state_q == IDLE),
    .gnt       (gnt)
  );
  // gnt already includes req_valid, so any grant is an accepted request
  assign fin = (cnt_q == CW'(WIDTH - 1)) || (EARLY_EXIT && sh_q[0]);
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    last_d  = last_q;
    id_d    = id_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = SCAN;
        sh_d    = gnt[1] ? bus.req_data[2*WIDTH-1:WIDTH] : bus.req_data[WIDTH-1:0];
        acc_d   = 1'b0;
        cnt_d   = '0;
        id_d    = gnt[1];
        last_d  = gnt[1];
      end
      SCAN: begin
        acc_d = acc_q | sh_q[0];
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (fin) begin
          state_d = DONE;
          out_d   = acc_q | sh_q[0];
        end
      end
      DONE: state_d = bus.resp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      id_q    <= id_d;
      out_q   <= out_d;
    end
  end
  assign bus.req_ready  = gnt;
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_id    = id_q;
  assign bus.resp_out   = out_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_or_reduce_sched.sv
// tb_or_reduce_sched: scoreboard bench for a full-scan (dut0) and an early-exit (dut1) instance
module tb_or_reduce_sched;
  typedef struct packed {logic id; logic out;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]  rv[2];
  logic [31:0] rd[2];
  logic        rr[2];
  logic [1:0]  rdy[2];
  logic        vld[2], rid[2], rout[2], bsy[2];
  logic        ml[2];
  exp_t        sb0[$], sb1[$];
  int          n_chk = 0;
  int          n_fail = 0;
  or_reduce_sched_if #(.WIDTH(16)) if0 ();
  or_reduce_sched_if #(.WIDTH(16)) if1 ();
  assign if0.req_valid  = rv[0];
  assign if0.req_data   = rd[0];
  assign if0.resp_ready = rr[0];
  assign if1.req_valid  = rv[1];
  assign if1.req_data   = rd[1];
  assign if1.resp_ready = rr[1];
  assign rdy[0] = if0.req_ready;
  assign vld[0] = if0.resp_valid;
  assign rid[0] = if0.resp_id;
  assign rout[0] = if0.resp_out;
  assign bsy[0] = if0.busy;
  assign rdy[1] = if1.req_ready;
  assign vld[1] = if1.resp_valid;
  assign rid[1] = if1.resp_id;
  assign rout[1] = if1.resp_out;
  assign bsy[1] = if1.busy;
  or_reduce_sched #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  or_reduce_sched #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // response monitors: every handshake must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && vld[0] && rr[0]) begin
      n_chk++;
      if (sb0.size() == 0) begin
        n_fail++;
        $display("FAIL resp0_unexpected: got id=%0d out=%0d, required no response", rid[0], rout[0]);
      end else begin
        exp_t e;
        e = sb0.pop_front();
        if ({rid[0], rout[0]} !== e) begin
          n_fail++;
          $display("FAIL resp0: got id=%0d out=%0d, required id=%0d out=%0d", rid[0], rout[0], e.id, e.out);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && vld[1] && rr[1]) begin
      n_chk++;
      if (sb1.size() == 0) begin
        n_fail++;
        $display("FAIL resp1_unexpected: got id=%0d out=%0d, required no response", rid[1], rout[1]);
      end else begin
        exp_t e;
        e = sb1.pop_front();
        if ({rid[1], rout[1]} !== e) begin
          n_fail++;
          $display("FAIL resp1: got id=%0d out=%0d, required id=%0d out=%0d", rid[1], rout[1], e.id, e.out);
        end
      end
    end
  end

  task automatic push(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic run_one(input int d, input int r, input logic [15:0] w, input int exp_cyc, input bit scramble);
    int cyc;
    @(posedge clk); #1;
    rv[d] = 2'b00;
    rv[d][r] = 1'b1;
    rd[d][r*16 +: 16] = w;
    @(negedge clk);
    n_chk++;
    if (rdy[d] !== 2'(1 << r)) begin
      n_fail++;
      $display("FAIL grant_d%0d: req_ready=%b, required %b", d, rdy[d], 2'(1 << r));
    end
    push(d, exp_t'{id: r[0], out: |w});
    ml[d] = r[0];
    @(posedge clk); #1;
    rv[d] = 2'b00;
    if (scramble) rd[d] = ~rd[d];
    cyc = 0;
    do begin
      cyc++;
      @(negedge clk);
    end while (!vld[d] && cyc < 100);
    n_chk++;
    if (cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL latency_d%0d_w%h: resp_valid in cycle %0d, required %0d", d, w, cyc, exp_cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 2'b00;
      rd[d] = '0;
      rr[d] = 1'b1;
      ml[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({vld[d], rout[d], rid[d], bsy[d], rdy[d]} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_state_d%0d: valid=%b out=%b id=%b busy=%b ready=%b, required all 0", d, vld[d], rout[d], rid[d], bsy[d], rdy[d]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // accept 8000 from requester 0, then reset in scan cycle 5
    @(posedge clk); #1;
    rv[0] = 2'b01;
    rd[0][15:0] = 16'h8000;
    @(negedge clk);
    n_chk++;
    if (rdy[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_pre_grant: req_ready=%b, required 01", rdy[0]);
    end
    @(posedge clk); #1;
    rv[0] = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bsy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy: busy=%b before reset edge, required 1", bsy[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ml[0] = 1'b1;
    ml[1] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bsy[0] !== 1'b0 || vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: busy=%b valid=%b, required 0 0", bsy[0], vld[0]);
    end
    repeat (30) @(posedge clk);
    // pointer must be back to 1, so requester 0 wins contention
    #1;
    rv[0] = 2'b11;
    rd[0] = {16'h0000, 16'h0004};
    @(negedge clk);
    n_chk++;
    if (rdy[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_pointer: req_ready=%b, required 01", rdy[0]);
    end
    push(0, exp_t'{id: 1'b0, out: 1'b1});
    ml[0] = 1'b0;
    @(posedge clk); #1;
    rv[0] = 2'b00;
    for (int t = 0; t < 40 && bsy[0]; t++) @(posedge clk);
    #1;
  endtask

  task automatic test_full_scan();
    run_one(0, 0, 16'h8000, 17, 1'b0);
    run_one(0, 0, 16'h0000, 17, 1'b0);
    run_one(0, 1, 16'h0001, 17, 1'b0);
  endtask

  task automatic test_early_exit();
    run_one(1, 0, 16'h8000, 17, 1'b0);
    run_one(1, 1, 16'h0008, 5, 1'b0);
    run_one(1, 1, 16'h0001, 2, 1'b0);
    run_one(1, 0, 16'h0000, 17, 1'b0);
    run_one(1, 1, 16'h0100, 10, 1'b0);
  endtask

  task automatic test_contention();
    logic exp_r;
    int t;
    @(posedge clk); #1;
    rd[1] = {16'h0000, 16'h0001};
    rv[1] = 2'b11;
    rr[1] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_r = ~ml[1];
      t = 0;
      do begin
        t++;
        @(negedge clk);
      end while (rdy[1] === 2'b00 && t < 50);
      n_chk++;
      if (rdy[1] !== (exp_r ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL contention_grant%0d: req_ready=%b, required %b", g, rdy[1], exp_r ? 2'b10 : 2'b01);
      end
      push(1, exp_t'{id: exp_r, out: ~exp_r});
      ml[1] = exp_r;
      t = 0;
      do begin
        t++;
        @(negedge clk);
      end while (!vld[1] && t < 50);
      n_chk++;
      if (vld[1] !== 1'b1 || rdy[1] !== 2'b00) begin
        n_fail++;
        $display("FAIL contention_done%0d: valid=%b req_ready=%b, required 1 00", g, vld[1], rdy[1]);
      end
    end
    @(posedge clk); #1;
    rv[1] = 2'b00;
    @(negedge clk);
    n_chk++;
    if (bsy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_idle: busy=%b, required 0", bsy[1]);
    end
  endtask

  task automatic test_backpressure();
    int t;
    @(posedge clk); #1;
    rr[0] = 1'b0;
    rv[0] = 2'b01;
    rd[0][15:0] = 16'h0010;
    @(negedge clk);
    n_chk++;
    if (rdy[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_grant: req_ready=%b, required 01", rdy[0]);
    end
    push(0, exp_t'{id: 1'b0, out: 1'b1});
    ml[0] = 1'b0;
    @(posedge clk); #1;
    rv[0] = 2'b11;
    t = 0;
    do begin
      t++;
      @(negedge clk);
    end while (!vld[0] && t < 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if ({vld[0], rout[0], rid[0], rdy[0]} !== 5'b11000) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b out=%b id=%b ready=%b, required 1 1 0 00", i, vld[0], rout[0], rid[0], rdy[0]);
      end
    end
    @(posedge clk); #1;
    rv[0] = 2'b00;
    rr[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (vld[0] !== 1'b0 || bsy[0] !== 1'b0 || sb0.size() != 0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b busy=%b pending=%0d, required 0 0 0", vld[0], bsy[0], sb0.size());
    end
  endtask

  task automatic test_data_isolation();
    run_one(0, 1, 16'h0000, 17, 1'b1);
    run_one(1, 0, 16'h0000, 17, 1'b1);
    run_one(1, 1, 16'h0040, 8, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_early_exit();
    test_contention();
    test_backpressure();
    test_data_isolation();
    repeat (5) @(posedge clk);
    n_chk++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending responses %0d/%0d, required 0/0", sb0.size(), sb1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
